truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively drives an external N_IN-input combinational function block.
- Steps through all 2**N_IN input vectors in ascending order.
- Waits a programmable settle time per vector, then samples the function output into a result register.
- Sits beside any combinational logic-function module as its stimulus and capture controller; start/done handshake toward a host or bench.

Parameters:
- N_IN, 4, number of function inputs; vector count = 2**N_IN.
- SETTLE_CYCLES, 2, clocks a vector is held before sampling; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled in IDLE only.
- abort  input  1  terminate the sweep in progress.
- f_in  output  N_IN  vector to the function block. For N_IN=4: bit3=x, bit2=y, bit1=w, bit0=z.
- f_s  input  1  function output, sampled in SAMPLE.
- table_out  output  2**N_IN  captured truth table; bit i = f_s at vector i.
- busy  output  1  high from the cycle after start until DONE is entered.
- done  output  1  one-cycle pulse after the last sample.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, f_in=0, table_out=0, busy=0, done=0, idx=0, settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start=1: f_in<=0, idx<=0, table_out<=0, cnt<=SETTLE_CYCLES-1, busy<=1, go SETTLE.
  - With start=0: hold all outputs.
- SETTLE:
  - If cnt==0, go SAMPLE; otherwise cnt<=cnt-1.
  - f_in stays stable throughout.
- SAMPLE:
  - table_out[idx]<=f_s.
  - If idx==2**N_IN-1: go DONE, busy<=0.
  - Otherwise: idx<=idx+1, f_in<=idx+1, cnt<=SETTLE_CYCLES-1, go SETTLE.
- DONE:
  - done=1 for exactly this cycle, then go IDLE.
  - table_out holds until the next start.
- Timing:
  - Each vector is driven for exactly SETTLE_CYCLES+1 clocks.
  - Start accepted at edge E → done high in the cycle after edge E + 2**N_IN·(SETTLE_CYCLES+1).
- start while busy or in DONE: ignored, no restart.
- abort=1 in SETTLE or SAMPLE:
  - Next state IDLE, busy<=0, done stays 0, f_in<=0.
  - table_out keeps the bits captured so far.
  - If abort and the final sample coincide, abort wins and the final bit is not written.
- abort in IDLE or DONE: no effect.
- idx and f_in do not wrap during a sweep; the terminal index forces DONE.
- Reset mid-sweep: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: SWEEP_CHECK_EN.
- Defined:
  - Adds input expected[2**N_IN-1:0], sampled at start.
  - Adds outputs mismatch (1) and first_fail (N_IN).
  - In SAMPLE, if f_s != expected[idx] and mismatch==0: mismatch<=1, first_fail<=idx.
  - Both are cleared at start and by reset.
  - Valid when done is high; hold until the next start.
- Undefined: ports absent; no compare logic.

Decomposition:
- Package sweep_pkg:
  - State enum sweep_state_t (IDLE, SETTLE, SAMPLE, DONE).
  - Localparam helper VEC_COUNT = 2**N_IN.
  - Settle counter width constant CNT_W = 8.
- Sub-module settle_timer:
  - Loadable down-counter; ports load, value, zero.
  - Instanced once; FSM and capture register remain in the top.

Test Plan:
- Golden sweep: f_s driven by s = (~w&~z)|(x&y&~w)|(~x&~y&w&z), SETTLE_CYCLES=2, start pulse → table_out=16'h3119; done exactly 48 clocks after the start edge; busy high throughout.
- Settle timing, SETTLE_CYCLES=1: f_in increments every 2 clocks, 0..15. With f_s=f_in[0] → table_out=16'hAAAA; done at clock 32.
- Abort: abort asserted while f_in=5 → busy=0 next cycle, no done, f_in=0, table_out bits 5..15 = 0. A new start then completes normally with table_out=16'h3119.
- start held high for the whole sweep: exactly one sweep and one done pulse. A second sweep begins only if start is still high in IDLE after DONE.
- Async reset at f_in=9: all outputs 0 immediately without a clock edge; the next start sweeps from 0.
- SWEEP_CHECK_EN: expected=16'h3119, golden function with bit 13 forced to 0 → mismatch=1, first_fail=13 at done. With the correct function → mismatch=0.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
// The SWEEP_CHECK_EN build option lives in the top module; nothing here depends on it.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam int N_IN_DEFAULT = 4;
    localparam int VEC_COUNT    = 1 << N_IN_DEFAULT;
    localparam int CNT_W        = 8;

    function automatic int vec_count(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that paces how long each vector is held.
// Counts down to zero and then holds there; zero flags the terminal count.
module settle_timer
    import sweep_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/capture sequencer for an N_IN-input combinational block.
// Optional build macro SWEEP_CHECK_EN adds a golden-table compare (expected/mismatch/first_fail).
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last sweep's results
// SETTLE | current vector driven, waiting for the settle counter to reach zero
// SAMPLE | capture f_s into table_out[idx], then advance or finish
// DONE   | one-cycle done pulse, then back to IDLE
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        f_in,
    input  logic                   f_s,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic                   busy,
    output logic                   done
`ifdef SWEEP_CHECK_EN
    ,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic                   mismatch,
    output logic [N_IN-1:0]        first_fail
`endif
);

    localparam int VEC = vec_count(N_IN);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  LAST_IDX    = N_IN'(VEC - 1);

    sweep_state_t    state_q, state_d;
    logic [N_IN-1:0] idx_q;
    logic            tmr_load, tmr_dec, tmr_zero;
    logic            accept, sample, quit;
    logic            last;

    settle_timer #(.W(CNT_W)) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (SETTLE_LOAD),
        .dec   (tmr_dec),
        .zero  (tmr_zero)
    );

    assign last = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // abort takes precedence over the sample, so a coinciding final bit is dropped
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        accept   = 1'b0;
        sample   = 1'b0;
        quit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    quit    = 1'b1;
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    quit    = 1'b1;
                    state_d = IDLE;
                end else begin
                    sample = 1'b1;
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        tmr_load = 1'b1;
                        state_d  = SETTLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_in      <= '0;
            idx_q     <= '0;
            table_out <= '0;
            busy      <= 1'b0;
        end else begin
            if (accept) begin
                f_in      <= '0;
                idx_q     <= '0;
                table_out <= '0;
                busy      <= 1'b1;
            end
            if (quit) begin
                f_in <= '0;
                busy <= 1'b0;
            end
            if (sample) begin
                table_out[idx_q] <= f_s;
                if (last) begin
                    busy <= 1'b0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                    f_in  <= idx_q + 1'b1;
                end
            end
        end
    end

    assign done = (state_q == DONE);

`ifdef SWEEP_CHECK_EN
    logic [VEC-1:0] expected_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected_q <= '0;
            mismatch   <= 1'b0;
            first_fail <= '0;
        end else if (accept) begin
            expected_q <= expected;
            mismatch   <= 1'b0;
            first_fail <= '0;
        end else if (sample && (f_s != expected_q[idx_q]) && !mismatch) begin
            mismatch   <= 1'b1;
            first_fail <= idx_q;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (settle 2 and settle 1) against a cycle-count model.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] tbl1 = '0;
    logic [15:0] tbl2 = '0;
    logic [15:0] expected = '0;

    logic [3:0]  f_in1, f_in2;
    logic        f_s1, f_s2;
    logic [15:0] table1, table2;
    logic        busy1, busy2, done1, done2;
    logic        mm1, mm2;
    logic [3:0]  ff1, ff2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign f_s1 = tbl1[f_in1];
    assign f_s2 = tbl2[f_in2];

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .f_in(f_in1), .f_s(f_s1), .table_out(table1), .busy(busy1), .done(done1)
`ifdef SWEEP_CHECK_EN
        , .expected(expected), .mismatch(mm1), .first_fail(ff1)
`endif
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .f_in(f_in2), .f_s(f_s2), .table_out(table2), .busy(busy2), .done(done2)
`ifdef SWEEP_CHECK_EN
        , .expected(expected), .mismatch(mm2), .first_fail(ff2)
`endif
    );

`ifndef SWEEP_CHECK_EN
    assign mm1 = 1'b0;
    assign mm2 = 1'b0;
    assign ff1 = '0;
    assign ff2 = '0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Model: a sweep is just a cycle count k since the accepting edge; vector = k/(S+1),
    // vector v is captured once k reaches (v+1)*(S+1), done at k == 16*(S+1).
    int          m_s[2] = '{2, 1};
    logic        m_act[2];
    logic        m_done[2];
    logic        m_busy[2];
    int          m_k[2];
    logic [3:0]  m_fin[2];
    logic [15:0] m_tbl[2];
    logic [15:0] m_exp[2];
    logic        m_mm[2];
    logic [3:0]  m_ff[2];
    int          mv;
    logic        mb;
    logic [15:0] mft;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_act[d] = 0; m_done[d] = 0; m_busy[d] = 0; m_k[d] = 0;
                m_fin[d] = 0; m_tbl[d] = 0; m_exp[d] = 0; m_mm[d] = 0; m_ff[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_done[d]) begin
                    m_done[d] = 0;
                end else if (m_act[d]) begin
                    if (abort) begin
                        m_act[d] = 0; m_busy[d] = 0; m_fin[d] = 0;
                    end else begin
                        if (m_k[d] % (m_s[d] + 1) == m_s[d]) begin
                            mv  = m_k[d] / (m_s[d] + 1);
                            mft = (d == 0) ? tbl1 : tbl2;
                            mb  = mft[mv];
                            m_tbl[d][mv] = mb;
                            if (mb != m_exp[d][mv] && !m_mm[d]) begin
                                m_mm[d] = 1; m_ff[d] = 4'(mv);
                            end
                        end
                        m_k[d]++;
                        if (m_k[d] == 16 * (m_s[d] + 1)) begin
                            m_act[d] = 0; m_busy[d] = 0; m_done[d] = 1;
                        end else begin
                            m_fin[d] = 4'(m_k[d] / (m_s[d] + 1));
                        end
                    end
                end else if (start) begin
                    m_act[d] = 1; m_k[d] = 0; m_fin[d] = 0; m_tbl[d] = 0; m_busy[d] = 1;
                    m_exp[d] = expected; m_mm[d] = 0; m_ff[d] = 0;
                end
            end
        end
    end

    task automatic cmp_dut(input int d, input logic [3:0] fin, input logic [15:0] tb,
                           input logic bz, input logic dn, input logic mm, input logic [3:0] ff);
        chk($sformatf("f_in%0d", d + 1), 32'(fin), 32'(m_fin[d]));
        chk($sformatf("table_out%0d", d + 1), 32'(tb), 32'(m_tbl[d]));
        chk($sformatf("busy%0d", d + 1), 32'(bz), 32'(m_busy[d]));
        chk($sformatf("done%0d", d + 1), 32'(dn), 32'(m_done[d]));
`ifdef SWEEP_CHECK_EN
        chk($sformatf("mismatch%0d", d + 1), 32'(mm), 32'(m_mm[d]));
        chk($sformatf("first_fail%0d", d + 1), 32'(ff), 32'(m_ff[d]));
`endif
    endtask

    always @(posedge clk or negedge rst_n) begin
        #1;
        cmp_dut(0, f_in1, table1, busy1, done1, mm1, ff1);
        cmp_dut(1, f_in2, table2, busy2, done2, mm2, ff2);
    end

    function automatic logic [15:0] gold_fn();
        logic [15:0] t;
        logic [3:0]  v;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            t[i] = (~v[1] & ~v[0]) | (v[3] & v[2] & ~v[1]) | (~v[3] & ~v[2] & v[1] & v[0]);
        end
        return t;
    endfunction

    function automatic logic [15:0] lsb_fn();
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[i] = (i % 2 == 1);
        return t;
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((m_act[0] || m_done[0] || m_act[1] || m_done[1]) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) chk("wait_idle_timeout", 32'(n), 32'(0));
        @(negedge clk);
    endtask

    task automatic wait_fin1(input logic [3:0] val);
        int n = 0;
        @(negedge clk);
        while (f_in1 !== val && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_f_in_timeout", 32'(f_in1), 32'(val));
    endtask

    logic [15:0] gold;
    int t0, t1, t2, n, busy_cnt, done_cnt;
    logic got1, got2;

    initial begin
        gold = gold_fn();
        chk("gold_literal", 32'(gold), 32'h3119);
        chk("lsb_literal", 32'(lsb_fn()), 32'hAAAA);
        repeat (3) @(negedge clk);
        chk("reset_table", 32'(table1), 32'h0);
        chk("reset_busy", 32'(busy1), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // golden sweep with latency and busy-length pins
        tbl1 = gold; tbl2 = lsb_fn(); expected = 16'h3119;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 t0 = cyc;
        busy_cnt = busy1 ? 1 : 0;
        @(negedge clk) start = 1'b0;
        n = 0; got1 = 0; got2 = 0; t1 = 0; t2 = 0;
        while (!(got1 && got2) && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (busy1) busy_cnt++;
            if (done1 && !got1) begin got1 = 1; t1 = cyc; end
            if (done2 && !got2) begin got2 = 1; t2 = cyc; end
        end
        chk("done1_latency", 32'(t1 - t0), 32'd48);
        chk("done2_latency", 32'(t2 - t0), 32'd32);
        chk("busy1_cycles", 32'(busy_cnt), 32'd48);
        @(negedge clk);
        chk("golden_table1", 32'(table1), 32'h3119);
        chk("lsb_table2", 32'(table2), 32'hAAAA);
`ifdef SWEEP_CHECK_EN
        chk("golden_mismatch", 32'(mm1), 32'd0);
`endif
        wait_idle(300);

        // golden function with bit 13 forced low
        tbl1 = gold & ~16'h2000;
        pulse_start();
        wait_idle(300);
        chk("bit13_table", 32'(table1), 32'h1119);
`ifdef SWEEP_CHECK_EN
        chk("bit13_mismatch", 32'(mm1), 32'd1);
        chk("bit13_first_fail", 32'(ff1), 32'd13);
`endif

        // abort while vector 5 is driven
        tbl1 = gold;
        pulse_start();
        wait_fin1(4'd5);
        abort = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_f_in", 32'(f_in1), 32'd0);
        chk("abort_table", 32'(table1), 32'h0019);
        @(negedge clk) abort = 1'b0;
        done_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done1) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        wait_idle(300);
        pulse_start();
        wait_idle(300);
        chk("restart_table", 32'(table1), 32'h3119);

        // start held for the whole sweep of dut1
        tbl1 = 16'(($urandom));
        @(negedge clk) start = 1'b1;
        n = 0; done_cnt = 0;
        while (done_cnt == 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (done1) done_cnt++;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_start_done_count", 32'(done_cnt), 32'd1);
        chk("held_start_no_restart", 32'(busy1), 32'd0);
        wait_idle(300);

        // async reset at vector 9, then a clean sweep from 0
        tbl1 = gold;
        pulse_start();
        wait_fin1(4'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_f_in", 32'(f_in1), 32'd0);
        chk("rst_table", 32'(table1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_f_in", 32'(f_in1), 32'd0);
        chk("post_rst_busy", 32'(busy1), 32'd1);
        @(negedge clk) start = 1'b0;
        wait_idle(300);
        chk("post_rst_table", 32'(table1), 32'h3119);

        // randomized sweeps, random start hold, occasional abort
        for (int it = 0; it < 20; it++) begin
            tbl1 = 16'($urandom);
            tbl2 = 16'($urandom);
            expected = ($urandom_range(0, 1) == 0) ? tbl1 : 16'($urandom);
            @(negedge clk) start = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 50)) @(negedge clk);
                abort = 1'b1;
                @(negedge clk) abort = 1'b0;
            end
            wait_idle(300);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
